// File: rtl/hack_ctrl_pkg.sv
// Shared constants, state encoding and output bundle for the Hack ALU control sequencer.
// HACK_ALU_CTRL_ILLEGAL_TRAP_EN enables the TRAP state and the illegal-instruction checks below.
package hack_ctrl_pkg;

    localparam int INSTR_W  = 16;
    localparam int TYPE_BIT = 15;
    localparam int RSVD_MSB = 14;
    localparam int RSVD_LSB = 13;
    localparam int A_BIT    = 12;
    localparam int COMP_MSB = 11;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JUMP_MSB = 2;
    localparam int JUMP_LSB = 0;

    localparam int N_COMP = 18;
    localparam logic [5:0] VALID_COMP [N_COMP] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
`ifdef HACK_ALU_CTRL_ILLEGAL_TRAP_EN
        ST_COMMIT = 3'd3,
        ST_TRAP   = 3'd4
`else
        ST_COMMIT = 3'd3
`endif
    } ctrl_state_t;

    typedef struct packed {
        logic       instr_ready;
        logic [5:0] alu_ctrl;
        logic       sel_am;
        logic       sel_a_src;
        logic       load_a;
        logic       load_d;
        logic       write_m;
        logic       load_pc;
        logic       inc_pc;
        logic       done;
        logic       illegal;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_RESET = '{
        instr_ready: 1'b1, alu_ctrl: 6'b000000, sel_am: 1'b0, sel_a_src: 1'b0,
        load_a: 1'b0, load_d: 1'b0, write_m: 1'b0, load_pc: 1'b0,
        inc_pc: 1'b0, done: 1'b0, illegal: 1'b0
    };

    function automatic logic comp_is_valid(input logic [5:0] comp);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_COMP; i++) begin
            if (comp == VALID_COMP[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic c_instr_is_illegal(input logic [INSTR_W-1:0] ins);
        return (ins[RSVD_MSB:RSVD_LSB] != 2'b11) || !comp_is_valid(ins[COMP_MSB:COMP_LSB]);
    endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// Hack jump-condition evaluator: j1 = less-than, j2 = equal, j3 = greater-than.
module hack_jump_cond (
    input  logic [2:0] j,
    input  logic       zr_q,
    input  logic       ng_q,
    output logic       jump
);

    // Jump taken when any selected comparison matches the sampled flags.
    always_comb begin
        jump = (j[2] & ng_q) | (j[1] & zr_q) | (j[0] & ~ng_q & ~zr_q);
    end

endmodule

// File: rtl/hack_alu_ctrl.sv
// Multi-cycle Hack instruction sequencer driving ALU controls and datapath strobes.
// Optional HACK_ALU_CTRL_ILLEGAL_TRAP_EN traps illegal C-instructions in a sticky TRAP state.
module hack_alu_ctrl
    import hack_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    output logic        sel_am,
    input  logic        zr,
    input  logic        ng,
    output logic        sel_a_src,
    output logic        load_a,
    output logic        load_d,
    output logic        write_m,
    output logic        load_pc,
    output logic        inc_pc,
    output logic        done,
    output logic        illegal
);

    ctrl_state_t          state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 zr_q, zr_d;
    logic                 ng_q, ng_d;
    ctrl_out_t            out_q, out_d;
    logic                 jump_s;

    // Jump is evaluated on next-cycle values so the COMMIT outputs can be registered.
    hack_jump_cond u_jump_cond (
        .j    (instr_d[JUMP_MSB:JUMP_LSB]),
        .zr_q (zr_d),
        .ng_q (ng_d),
        .jump (jump_s)
    );

    // Next-state, instruction latch and flag capture.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = instr[TYPE_BIT] ? ST_DECODE : ST_COMMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
`ifdef HACK_ALU_CTRL_ILLEGAL_TRAP_EN
                if (c_instr_is_illegal(instr_q)) begin
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
`else
                state_d = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                zr_d    = zr;
                ng_d    = ng;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
`ifdef HACK_ALU_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:   state_d = ST_TRAP;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state being entered, then registered.
    always_comb begin
        out_d = '0;
        case (state_d)
            ST_IDLE: out_d.instr_ready = 1'b1;
            ST_DECODE, ST_EXEC: begin
                out_d.alu_ctrl = instr_d[COMP_MSB:COMP_LSB];
                out_d.sel_am   = instr_d[A_BIT];
            end
            ST_COMMIT: begin
                out_d.done = 1'b1;
                if (instr_d[TYPE_BIT]) begin
                    out_d.alu_ctrl = instr_d[COMP_MSB:COMP_LSB];
                    out_d.sel_am   = instr_d[A_BIT];
                    out_d.load_a   = instr_d[DEST_A];
                    out_d.load_d   = instr_d[DEST_D];
                    out_d.write_m  = instr_d[DEST_M];
                    out_d.load_pc  = jump_s;
                    out_d.inc_pc   = ~jump_s;
                end else begin
                    out_d.load_a    = 1'b1;
                    out_d.sel_a_src = 1'b1;
                    out_d.inc_pc    = 1'b1;
                end
            end
`ifdef HACK_ALU_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: out_d.illegal = 1'b1;
`endif
            default: out_d = CTRL_OUT_RESET;
        endcase
    end

    // State, latched instruction, sampled flags and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
            out_q   <= CTRL_OUT_RESET;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            out_q   <= out_d;
        end
    end

    assign instr_ready              = out_q.instr_ready;
    assign {zx, nx, zy, ny, f, no}  = out_q.alu_ctrl;
    assign sel_am                   = out_q.sel_am;
    assign sel_a_src                = out_q.sel_a_src;
    assign load_a                   = out_q.load_a;
    assign load_d                   = out_q.load_d;
    assign write_m                  = out_q.write_m;
    assign load_pc                  = out_q.load_pc;
    assign inc_pc                   = out_q.inc_pc;
    assign done                     = out_q.done;
    assign illegal                  = out_q.illegal;

endmodule

// File: doc/hack_alu_ctrl.md
# hack_alu_ctrl

Multi-cycle control sequencer that drives the Hack ALU's six control inputs and consumes its `zr`/`ng` flags. It is the other end of the ALU control/flag interface.
- It accepts one 16-bit Hack instruction at a time over a valid/ready handshake.
- It sequences the ALU through decode and execute, samples the flags, and evaluates the jump condition.
- It issues one cycle of register-load and PC-update strobes to the CPU datapath.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  `instr` holds an instruction
- `instr`  in  16  Hack instruction
- `instr_ready`  out  1  controller can accept (high only in IDLE)
- `zx`, `nx`, `zy`, `ny`, `f`, `no`  out  1 each  ALU control bits
- `sel_am`  out  1  ALU y operand: 1 = M, 0 = A
- `zr`, `ng`  in  1 each  ALU flags
- `sel_a_src`  out  1  A-register source: 1 = `instr[14:0]`, 0 = ALU out
- `load_a`, `load_d`, `write_m`  out  1 each  datapath write strobes
- `load_pc`  out  1  jump taken
- `inc_pc`  out  1  sequential PC advance
- `done`  out  1  one-cycle retire pulse
- `illegal`  out  1  sticky trap flag (only with the macro)

## Operation
- States: IDLE, DECODE, EXEC, COMMIT, TRAP (TRAP exists only with the macro).
- IDLE:
  - `instr_ready` = 1.
  - Handshake fires when `instr_valid & instr_ready` are high on a rising edge; `instr` is latched internally.
  - If `instr[15]` = 0 (A-instruction), next state is COMMIT. Otherwise (C-instruction) next state is DECODE.
- DECODE:
  - Drives `{zx,nx,zy,ny,f,no}` = `instr[11:6]` and `sel_am` = `instr[12]` from the latched copy.
  - These outputs hold through EXEC and COMMIT.
- EXEC: the ALU settles. On the exiting edge, `zr` and `ng` are captured into `zr_q`/`ng_q`.
- COMMIT, A-instruction:
  - `load_a` = 1, `sel_a_src` = 1, `inc_pc` = 1, `done` = 1.
  - ALU control bits stay 0.
- COMMIT, C-instruction:
  - `load_a` = `d1` (`instr[5]`), `sel_a_src` = 0, `load_d` = `d2` (`instr[4]`), `write_m` = `d3` (`instr[3]`).
  - `jump` = (`j1` & `ng_q`) | (`j2` & `zr_q`) | (`j3` & ~`ng_q` & ~`zr_q`), with `j1..j3` = `instr[2:0]`.
  - `load_pc` = `jump`, `inc_pc` = ~`jump`, `done` = 1.
- Exactly one of `load_pc` and `inc_pc` is high in COMMIT; both are 0 in every other state.
- COMMIT always returns to IDLE.
- All strobes are 0 outside COMMIT. ALU control bits and `sel_am` are 0 in IDLE.
- `instr` and `instr_valid` are ignored outside IDLE. No instruction is accepted in the COMMIT cycle.

## Timing
- Reset values: state IDLE.
  - Outputs: `instr_ready` = 1.
  - All other outputs 0: `zx..no`, `sel_am`, `sel_a_src`, `load_a`, `load_d`, `write_m`, `load_pc`, `inc_pc`, `done`, `illegal`.
  - Internal registers: `zr_q` = 0, `ng_q` = 0.
- Latency, measured from the handshake edge (cycle 0):
  - A-instruction: `done` in cycle 1. Next accept possible in cycle 2.
  - C-instruction: DECODE in cycle 1, EXEC in cycle 2, `done` in cycle 3. Next accept possible in cycle 4.
- Flags are sampled only at the end of EXEC. Flag changes during COMMIT have no effect.
- Reset asserted in any state:
  - IDLE on the next edge, with all outputs at reset values.
  - The in-flight instruction is discarded, and no strobe is issued for it.
- Reset has priority over a simultaneous handshake.

## Configuration
- Macro: `HACK_ALU_CTRL_ILLEGAL_TRAP_EN`.
- Defined: a C-instruction is illegal if either condition holds:
  - `instr[14:13]` != 2'b11, or
  - `instr[11:6]` is not one of the 18 valid comp codes: 101010, 111111, 111010, 001100, 110000, 001101, 110001, 001111, 110011, 011111, 110111, 001110, 110010, 000010, 010011, 000111, 000000, 010101.
- Illegal instruction handling: detected in DECODE; the next state is TRAP.
  - In TRAP, `illegal` = 1 and `instr_ready` = 0, and no strobes or `done` are issued.
  - TRAP is left only by `reset`.
- Undefined:
  - `instr[14:13]` is a don't-care, and any comp code is executed as given.
  - `illegal` is tied to 0, and TRAP does not exist.

## Structure
- Shared package `hack_ctrl_pkg` holds:
  - state encoding;
  - instruction field positions (`a`, comp, dest, jump);
  - the valid-comp-code list.
- Sub-module `hack_jump_cond`: combinational; inputs `j[2:0]`, `zr_q`, `ng_q`; output `jump`. It is reused by the CPU top.

## Test plan
- Reset, then `instr` = 0x0005 (A-instruction) → cycle 1: `load_a` = 1, `sel_a_src` = 1, `inc_pc` = 1, `done` = 1; cycle 2: `instr_ready` = 1.
- `instr` = 0xEC10 (D=A) with ALU forced `zr` = 0, `ng` = 0 → cycles 1–3: `zx..no` = 110000, `sel_am` = 0; cycle 3: `load_d` = 1, `inc_pc` = 1, `load_pc` = 0, `done` = 1.
- `instr` = 0xE302 (D;JEQ): with `zr` = 1 in EXEC → `load_pc` = 1, `inc_pc` = 0; repeat with `zr` = 0 → `inc_pc` = 1.
- `instr` = 0xFC07 (M;JMP) with `ng` = 1 → cycle 3: `sel_am` = 1, `load_pc` = 1, `write_m` = 0.
- `reset` pulsed in EXEC of 0xEC18 → next cycle IDLE, `instr_ready` = 1, no `load_d`, `write_m` or `done` ever seen for that instruction.
- With `HACK_ALU_CTRL_ILLEGAL_TRAP_EN`: `instr` = 0xE000 (comp 000000, legal) retires normally; `instr` = 0xE040 (comp 000001) → cycle 2: `illegal` = 1, `instr_ready` = 0; both held until `reset`.
